// File: rtl/pkg_tpu.sv
// Shared TPU backend types used by the shared multiplier path and its arbiter.
package pkg_tpu;

  typedef logic [31:0] data_t;
  typedef logic [7:0]  index_t;
  typedef logic [5:0]  issue_no_t;

  typedef enum logic [1:0] {
    OP_FMUL  = 2'd0,
    OP_FNMUL = 2'd1
  } opt_t;

  // Wide enough for up to 16 requesters sharing one unit.
  localparam int unsigned REQ_ID_W = 4;
  typedef logic [REQ_ID_W-1:0] req_id_t;

  // Bookkeeping that travels alongside an operation through the pipeline.
  typedef struct packed {
    logic      valid;
    req_id_t   id;
    index_t    index;
    issue_no_t issue_no;
  } mlt_tag_t;

endpackage

// File: rtl/fMlt_Unit.sv
// Combinational IEEE-754 single-precision multiplier (denormals flushed to zero,
// round to nearest even). FNMUL negates the product.
module fMlt_Unit
  import pkg_tpu::*;
(
  input  logic  I_En,
  input  logic  I_Stall,
  input  opt_t  I_Op,
  input  data_t I_Data1,
  input  data_t I_Data2,
  output logic  O_Valid,
  output data_t O_Data
);

  logic              w_sr;
  logic [7:0]        w_ea, w_eb;
  logic [47:0]       w_prod;
  logic signed [9:0] w_exp;
  logic [22:0]       w_mant;
  logic              w_g, w_st;
  logic [23:0]       w_mant_r;
  logic              w_nan_a, w_nan_b, w_inf_a, w_inf_b, w_zero_a, w_zero_b;
  data_t             w_res;

  // Multiply significands, normalise, round and handle special operands.
  always_comb begin
    w_ea     = I_Data1[30:23];
    w_eb     = I_Data2[30:23];
    w_sr     = I_Data1[31] ^ I_Data2[31] ^ (I_Op == OP_FNMUL);
    w_nan_a  = (w_ea == 8'hFF) && (I_Data1[22:0] != '0);
    w_nan_b  = (w_eb == 8'hFF) && (I_Data2[22:0] != '0);
    w_inf_a  = (w_ea == 8'hFF) && (I_Data1[22:0] == '0);
    w_inf_b  = (w_eb == 8'hFF) && (I_Data2[22:0] == '0);
    w_zero_a = (w_ea == 8'h00);
    w_zero_b = (w_eb == 8'h00);
    w_prod   = 48'({1'b1, I_Data1[22:0]}) * 48'({1'b1, I_Data2[22:0]});
    w_exp    = $signed(10'(w_ea) + 10'(w_eb) - 10'd127);
    if (w_prod[47]) begin
      w_mant = w_prod[46:24];
      w_g    = w_prod[23];
      w_st   = |w_prod[22:0];
      w_exp  = w_exp + 10'sd1;
    end else begin
      w_mant = w_prod[45:23];
      w_g    = w_prod[22];
      w_st   = |w_prod[21:0];
    end
    w_mant_r = {1'b0, w_mant} + 24'(w_g & (w_st | w_mant[0]));
    if (w_mant_r[23]) w_exp = w_exp + 10'sd1;
    if (w_nan_a || w_nan_b)        w_res = 32'h7FC0_0000;
    else if (w_inf_a || w_inf_b)   w_res = (w_zero_a || w_zero_b) ? 32'h7FC0_0000 : {w_sr, 8'hFF, 23'h0};
    else if (w_zero_a || w_zero_b) w_res = {w_sr, 31'h0};
    else if (w_exp >= 10'sd255)    w_res = {w_sr, 8'hFF, 23'h0};
    else if (w_exp <= 10'sd0)      w_res = {w_sr, 31'h0};
    else                           w_res = {w_sr, w_exp[7:0], w_mant_r[22:0]};
  end

  assign O_Data  = I_En ? w_res : '0;
  assign O_Valid = I_En & ~I_Stall;

endmodule

// File: rtl/rr_arbiter.sv
// One-hot round-robin pick with pointer update; reusable by any shared unit.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_hold,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_win,
  output logic          o_any
);

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_win;
  logic          w_any;
  int unsigned   w_sum;

  // Search from the pointer, wrapping, for the first active request.
  always_comb begin
    o_grant = '0;
    w_win   = '0;
    w_any   = 1'b0;
    w_sum   = 0;
    w_idx   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      w_sum = 32'(r_ptr) + off;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = PW'(w_sum);
      if (!w_any && !i_hold && i_req[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
    if (w_any) o_grant[w_win] = 1'b1;
  end

  assign o_win = w_win;
  assign o_any = w_any;

  // Pointer moves just past the winner; held when nothing is granted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (w_any) begin
      r_ptr <= (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;
    end
  end

endmodule

// File: rtl/fmlt_arbiter.sv
// Shares one fMlt_Unit among NUM_REQ requesters: round-robin acceptance into S0,
// fixed-latency delay line carrying the tag, and in-flight occupancy tracking.
module fmlt_arbiter
  import pkg_tpu::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned MLT_LATENCY = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       I_Stall,
  input  logic      [NUM_REQ-1:0]    I_Req,
  input  opt_t      [NUM_REQ-1:0]    I_Op,
  input  data_t     [NUM_REQ-1:0]    I_Data1,
  input  data_t     [NUM_REQ-1:0]    I_Data2,
  input  index_t    [NUM_REQ-1:0]    I_Index,
  input  issue_no_t [NUM_REQ-1:0]    I_Issue_No,
  output logic      [NUM_REQ-1:0]    O_Grant,
  output logic      [NUM_REQ-1:0]    O_Valid,
  output data_t                      O_Data,
  output index_t                     O_Index,
  output issue_no_t                  O_Issue_No,
  output logic                       O_Busy
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(MLT_LATENCY + 2);

  logic          w_hold;
  logic [PW-1:0] w_win;
  logic          w_acc;
  logic          w_ret;
  logic          w_mlt_valid;
  data_t         w_mlt_data;
  mlt_tag_t      w_last;

  mlt_tag_t      r_s0_tag;
  opt_t          r_s0_op;
  data_t         r_s0_d1;
  data_t         r_s0_d2;
  mlt_tag_t      r_d_tag  [MLT_LATENCY];
  data_t         r_d_data [MLT_LATENCY];
  logic [CW-1:0] r_cnt;

  // Reset also blocks grants so every output reads zero while it is held.
  assign w_hold = I_Stall | ~reset;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_clk   (clock),
    .i_rst_n (reset),
    .i_hold  (w_hold),
    .i_req   (I_Req),
    .o_grant (O_Grant),
    .o_win   (w_win),
    .o_any   (w_acc)
  );

  // S0: capture the winning requester's operands and tag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s0_tag <= '0;
      r_s0_op  <= OP_FMUL;
      r_s0_d1  <= '0;
      r_s0_d2  <= '0;
    end else if (!I_Stall) begin
      r_s0_tag.valid <= w_acc;
      if (w_acc) begin
        r_s0_tag.id       <= REQ_ID_W'(w_win);
        r_s0_tag.index    <= I_Index[w_win];
        r_s0_tag.issue_no <= I_Issue_No[w_win];
        r_s0_op           <= I_Op[w_win];
        r_s0_d1           <= I_Data1[w_win];
        r_s0_d2           <= I_Data2[w_win];
      end
    end
  end

  fMlt_Unit u_mlt (
    .I_En    (r_s0_tag.valid),
    .I_Stall (I_Stall),
    .I_Op    (r_s0_op),
    .I_Data1 (r_s0_d1),
    .I_Data2 (r_s0_d2),
    .O_Valid (w_mlt_valid),
    .O_Data  (w_mlt_data)
  );

  // Delay line D1..Dn; bubbles advance freely, everything freezes on stall.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < MLT_LATENCY; i++) begin
        r_d_tag[i]  <= '0;
        r_d_data[i] <= '0;
      end
    end else if (!I_Stall) begin
      r_d_tag[0]  <= {w_mlt_valid, r_s0_tag.id, r_s0_tag.index, r_s0_tag.issue_no};
      r_d_data[0] <= w_mlt_data;
      for (int unsigned i = 1; i < MLT_LATENCY; i++) begin
        r_d_tag[i]  <= r_d_tag[i-1];
        r_d_data[i] <= r_d_data[i-1];
      end
    end
  end

  assign w_last = r_d_tag[MLT_LATENCY-1];
  assign w_ret  = w_last.valid & ~I_Stall;

  // Return the last-stage result to its requester; zero when nothing retires.
  always_comb begin
    O_Valid    = '0;
    O_Data     = '0;
    O_Index    = '0;
    O_Issue_No = '0;
    if (w_ret) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (w_last.id == REQ_ID_W'(k)) O_Valid[k] = 1'b1;
      end
      O_Data     = r_d_data[MLT_LATENCY-1];
      O_Index    = w_last.index;
      O_Issue_No = w_last.issue_no;
    end
  end

  // In-flight count: up on acceptance, down on retirement, both cancel.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else begin
      case ({w_acc, w_ret})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign O_Busy = (r_cnt != '0);

endmodule
